// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with operand-forwarding select generation and load-use stall.
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_fwd_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_we,
    input  logic              id_mem_read,
    input  logic              id_alu_a_pc,
    input  logic              id_alu_b_imm,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_we,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_we,
    output logic              ex_mem_read,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic [1:0]        sel_st,
    output logic              stall_id
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_alu_a_pc;
    logic              ex_alu_b_imm;
    logic              hz;
    logic [1:0]        fwd_rs1;
    logic [1:0]        fwd_rs2;

    // Both sources are compared even if the consumer does not read them.
    assign hz = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));

    assign stall_id = hz & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_reg_we    <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_alu_a_pc  <= 1'b0;
            ex_alu_b_imm <= 1'b0;
        end else if (flush || hz) begin
            ex_valid    <= 1'b0;
            ex_reg_we   <= 1'b0;
            ex_mem_read <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1_data  <= id_rs1_data;
            ex_rs2_data  <= id_rs2_data;
            ex_imm       <= id_imm;
            ex_rd        <= id_rd;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_reg_we    <= id_reg_we & id_valid;
            ex_mem_read  <= id_mem_read & id_valid;
            ex_alu_a_pc  <= id_alu_a_pc;
            ex_alu_b_imm <= id_alu_b_imm;
        end
    end

    // MEM result is younger than WB, so it wins when both match.
    always_comb begin
        fwd_rs1 = 2'b00;
        if (mem_reg_we && (mem_rd != '0) && (mem_rd == ex_rs1))
            fwd_rs1 = 2'b01;
        else if (wb_reg_we && (wb_rd != '0) && (wb_rd == ex_rs1))
            fwd_rs1 = 2'b10;
    end

    always_comb begin
        fwd_rs2 = 2'b00;
        if (mem_reg_we && (mem_rd != '0) && (mem_rd == ex_rs2))
            fwd_rs2 = 2'b01;
        else if (wb_reg_we && (wb_rd != '0) && (wb_rd == ex_rs2))
            fwd_rs2 = 2'b10;
    end

    always_comb begin
        sel_a  = 2'b00;
        sel_b  = 2'b00;
        sel_st = 2'b00;
        if (ex_valid) begin
            sel_a  = ex_alu_a_pc  ? 2'b11 : fwd_rs1;
            sel_b  = ex_alu_b_imm ? 2'b11 : fwd_rs2;
            sel_st = fwd_rs2;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_id)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
